fwrisc_fetch_decode: RTL and testbench
======================================

# fwrisc_fetch_decode

Fetch/decode front end of the fwrisc core. It is the producer side of the execute interface. It fetches a 32-bit instruction from the instruction bus at the PC supplied by `fwrisc_exec`, then reads the source registers. It decodes the instruction into `op_type`/`op`/`op_a`/`op_b`/`op_c`/`rd` and holds `decode_valid` until `fwrisc_exec` reports `instr_complete`.

## Interface
- `ENABLE_MUL_DIV`, default 1: when 0, RV32M encodings (OP, funct7=0000001) are illegal.

Ports:
- `clock` in 1: single clock.
- `reset` in 1: reset is asynchronous and active-low.
- `iaddr` out 32: fetch address; always equals `pc`.
- `ivalid` out 1: fetch request.
- `iready` in 1: fetch acknowledge; `idata` is valid in the same cycle.
- `idata` in 32: instruction word.
- `ra_raddr`, `rb_raddr` out 6: regfile read addresses. The regfile has a synchronous 1-cycle read and returns 0 for x0.
- `ra_rdata`, `rb_rdata` in 32: regfile read data.
- `pc` in 32, `pc_seq` in 1: from `fwrisc_exec`. `pc_seq` is unused except for debug tap.
- `instr_complete` in 1: from `fwrisc_exec`, registered.
- `decode_valid` out 1, `instr_c` out 1 (tied 0), `op_type` out 5, `op` out 6, `op_a`/`op_b`/`op_c` out 32, `rd` out 6.
- `illegal` out 1: sticky illegal-instruction flag.

## Operation
- FSM states: FETCH, DECODE, EXEC, HALT.
- FETCH:
  - `ivalid`=1 and `iaddr`=`pc`.
  - On `iready`, capture `idata` into `instr` and go to DECODE.
- DECODE (1 cycle):
  - Drive `ra_raddr`=`instr[19:15]` and `rb_raddr`=`instr[24:20]` (zero-extended).
  - If `instr[1:0]`!=2'b11, or the opcode/funct is not RV32IM (or M is disabled): set `illegal` and go to HALT.
  - Otherwise go to EXEC.
- EXEC:
  - `decode_valid` = 1 && !`instr_complete` (combinational clear, so `fwrisc_exec` never re-executes).
  - On `instr_complete`, go to FETCH.
  - `raddr` is held constant, so `ra_rdata`/`rb_rdata` stay stable.
- HALT: all request outputs are 0 until reset.
- Decoded fields are combinational from `instr`, the regfile data, and `pc`. Immediates are sign-extended to 32 bits.
- Field mapping by instruction:
  - OP/OP-IMM (non-shift): ARITH, `op`=ALU code, `op_a`=rs1, `op_b`=rs2 or I-imm.
  - SLL/SRL/SRA(I), MUL*/DIV*/REM*: MDS, `op_a`=rs1, `op_b`=rs2 or shamt.
  - LUI: ARITH ADD, `op_a`=U-imm, `op_b`=0.
  - AUIPC: ARITH ADD, `op_a`=`pc`, `op_b`=U-imm.
  - Branch: BRANCH, `op`=EQ/NE/LT/GE/LTU/GEU, `op_a`=rs1, `op_b`=rs2, `op_c`=B-imm.
  - JAL: JUMP, `op`=ADD, `op_a`=`pc`, `op_b`=0, `op_c`=J-imm.
  - JALR: JUMP, `op_a`=rs1, `op_b`=0, `op_c`=I-imm.
  - Load/store: LDST, `op`=width/sign code, `op_a`=rs1, `op_b`=rs2, `op_c`=I- or S-imm.
  - FENCE: ARITH ADD with `rd`=0.
  - SYSTEM: CSR, `op_a`=rs1 or zimm, `op_c`=csr[11:0].
- `rd`=`instr[11:7]`, except branch, store, and FENCE, which use `rd`=0.

## Timing
- Reset values: `ivalid`=0, `decode_valid`=0, `illegal`=0, `raddr`s=0, `instr`=0 (outputs decoded from 0 are don't-care while `decode_valid`=0). State is FETCH.
- First `ivalid` appears in the first clock after reset deassertion.
- Latency: `iready` in cycle N, then DECODE in N+1, then `decode_valid` in N+2.
- `instr_complete` in cycle M:
  - `decode_valid`=0 in M.
  - `ivalid`=1 in M+1 at the new `pc`.
  - Minimum is 3 cycles per instruction beyond the fetch wait.
- `ivalid` and `iaddr` are held stable until `iready`. No request is ever withdrawn, except by reset.
- Reset mid-FETCH or mid-EXEC: `ivalid` and `decode_valid` drop asynchronously. A late `iready` after reset is ignored unless the block is in FETCH.

## Structure
- Shared package `fwrisc_pkg` holds:
  - `op_type` constants (ARITH, BRANCH, LDST, MDS, JUMP, CALL, CSR).
  - ALU/branch/LDST/MDS op codes.
  - RV32 opcode constants.
  - The FSM state enum.
- Sub-module `fwrisc_imm_gen`: combinational I/S/B/U/J immediate extraction from `instr`.

## Test plan
- ADDI x1,x0,5 (0x00500093) at `pc` 0x8000_0000:
  - `iaddr`=0x80000000.
  - `decode_valid` 2 cycles after `iready`, with ARITH/ADD, `op_a`=0, `op_b`=5, `rd`=1.
  - `instr_complete` drops `decode_valid` in the same cycle; `ivalid` is high the next cycle.
- BEQ x1,x2,-8 (0xFE208CE3): `raddr` 1/2, BRANCH/EQ, `op_c`=0xFFFFFFF8, `rd`=0.
- JAL x1,+16 (0x010000EF) at 0x80000010: JUMP, `op_a`=0x80000010, `op_b`=0, `op_c`=16, `rd`=1.
- LUI x5,0x12345 (0x123452B7): ARITH/ADD, `op_a`=0x12345000, `op_b`=0, `rd`=5.
- Fetch handshake and reset:
  - `iready` delayed 3 cycles: `ivalid`/`iaddr` stable throughout.
  - Reset pulsed while `ivalid`=1: `ivalid`=0 immediately, refetch at the `pc` after release.
- Illegal handling:
  - `idata`=0x00000000: `illegal`=1 sticky, `decode_valid` never asserted, `ivalid` stays 0.
  - MUL 0x02208033 with `ENABLE_MUL_DIV`=0: `illegal`=1. With `ENABLE_MUL_DIV`=1: MDS decoded.

Source files
------------

// File: rtl/fwrisc_pkg.sv
// Shared definitions for the fwrisc fetch/decode front end.
// Holds the op_type classes, the ALU/branch/load-store/MDS/CSR op codes,
// the RV32 major opcodes, the fetch/decode state enum and the RV32IM
// legality check used while decoding.
package fwrisc_pkg;

  // Execution unit classes presented on op_type
  localparam logic [4:0] OP_TYPE_ARITH  = 5'd0;
  localparam logic [4:0] OP_TYPE_BRANCH = 5'd1;
  localparam logic [4:0] OP_TYPE_LDST   = 5'd2;
  localparam logic [4:0] OP_TYPE_MDS    = 5'd3;
  localparam logic [4:0] OP_TYPE_JUMP   = 5'd4;
  localparam logic [4:0] OP_TYPE_CALL   = 5'd5;
  localparam logic [4:0] OP_TYPE_CSR    = 5'd6;

  // ALU op codes
  localparam logic [5:0] OP_ADD  = 6'd0;
  localparam logic [5:0] OP_SUB  = 6'd1;
  localparam logic [5:0] OP_AND  = 6'd2;
  localparam logic [5:0] OP_OR   = 6'd3;
  localparam logic [5:0] OP_XOR  = 6'd4;
  localparam logic [5:0] OP_SLT  = 6'd5;
  localparam logic [5:0] OP_SLTU = 6'd6;

  // Branch compare codes
  localparam logic [5:0] OP_EQ  = 6'd0;
  localparam logic [5:0] OP_NE  = 6'd1;
  localparam logic [5:0] OP_LT  = 6'd2;
  localparam logic [5:0] OP_GE  = 6'd3;
  localparam logic [5:0] OP_LTU = 6'd4;
  localparam logic [5:0] OP_GEU = 6'd5;

  // Load/store width and sign codes
  localparam logic [5:0] OP_LB  = 6'd0;
  localparam logic [5:0] OP_LH  = 6'd1;
  localparam logic [5:0] OP_LW  = 6'd2;
  localparam logic [5:0] OP_LBU = 6'd3;
  localparam logic [5:0] OP_LHU = 6'd4;
  localparam logic [5:0] OP_SB  = 6'd5;
  localparam logic [5:0] OP_SH  = 6'd6;
  localparam logic [5:0] OP_SW  = 6'd7;

  // Multiply/divide/shift codes; MUL..REMU are contiguous in funct3 order
  localparam logic [5:0] OP_SLL    = 6'd0;
  localparam logic [5:0] OP_SRL    = 6'd1;
  localparam logic [5:0] OP_SRA    = 6'd2;
  localparam logic [5:0] OP_MUL    = 6'd3;
  localparam logic [5:0] OP_MULH   = 6'd4;
  localparam logic [5:0] OP_MULHSU = 6'd5;
  localparam logic [5:0] OP_MULHU  = 6'd6;
  localparam logic [5:0] OP_DIV    = 6'd7;
  localparam logic [5:0] OP_DIVU   = 6'd8;
  localparam logic [5:0] OP_REM    = 6'd9;
  localparam logic [5:0] OP_REMU   = 6'd10;

  // CSR codes equal funct3 zero-extended (0 covers ECALL/EBREAK/xRET)
  localparam logic [5:0] OP_CSRRW = 6'd1;
  localparam logic [5:0] OP_CSRRS = 6'd2;
  localparam logic [5:0] OP_CSRRC = 6'd3;

  // RV32 major opcodes (bits [1:0] are always 2'b11)
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef enum logic [1:0] {
    FD_FETCH  = 2'd0,
    FD_DECODE = 2'd1,
    FD_EXEC   = 2'd2,
    FD_HALT   = 2'd3
  } fd_state_e;

  // True when the word is a valid RV32I (and, if enabled, RV32M) encoding
  function automatic logic rv32im_legal(input logic [31:0] instr, input logic mul_div_en);
    logic [6:0] f7;
    logic [2:0] f3;
    logic       ok;
    f7 = instr[31:25];
    f3 = instr[14:12];
    ok = 1'b0;
    case (instr[6:0])
      OPC_LUI, OPC_AUIPC, OPC_JAL: ok = 1'b1;
      OPC_JALR:     ok = (f3 == 3'b000);
      OPC_BRANCH:   ok = (f3 != 3'b010) && (f3 != 3'b011);
      OPC_LOAD:     ok = (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
      OPC_STORE:    ok = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
      OPC_OP_IMM: begin
        if (f3 == 3'b001) begin
          ok = (f7 == 7'b0000000);
        end else if (f3 == 3'b101) begin
          ok = (f7 == 7'b0000000) || (f7 == 7'b0100000);
        end else begin
          ok = 1'b1;
        end
      end
      OPC_OP: begin
        if (f7 == 7'b0000000) begin
          ok = 1'b1;
        end else if (f7 == 7'b0100000) begin
          ok = (f3 == 3'b000) || (f3 == 3'b101);
        end else if (f7 == 7'b0000001) begin
          ok = mul_div_en;
        end else begin
          ok = 1'b0;
        end
      end
      OPC_MISC_MEM: ok = (f3 == 3'b000);
      OPC_SYSTEM:   ok = (f3 != 3'b100);
      default:      ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/fwrisc_imm_gen.sv
// Immediate extraction for RV32 instruction formats.
// Ports:
//   instr_i      - instruction word
//   imm_itype_o  - sign-extended I-type immediate
//   imm_stype_o  - sign-extended S-type immediate
//   imm_btype_o  - sign-extended B-type branch offset
//   imm_utype_o  - U-type immediate (upper 20 bits, low 12 zero)
//   imm_jtype_o  - sign-extended J-type jump offset
module fwrisc_imm_gen (
  input  logic [31:0] instr_i,
  output logic [31:0] imm_itype_o,
  output logic [31:0] imm_stype_o,
  output logic [31:0] imm_btype_o,
  output logic [31:0] imm_utype_o,
  output logic [31:0] imm_jtype_o
);

  assign imm_itype_o = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_stype_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign imm_btype_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                        instr_i[30:25], instr_i[11:8], 1'b0};
  assign imm_utype_o = {instr_i[31:12], 12'h000};
  assign imm_jtype_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                        instr_i[20], instr_i[30:21], 1'b0};

endmodule

// File: rtl/fwrisc_fetch_decode.sv
// Fetch/decode front end of the fwrisc core.
// Fetches one instruction at pc, issues register reads, decodes the word
// and holds decode_valid until the execute stage reports instr_complete.
// Ports:
//   clock, reset            - clock and asynchronous active-low reset
//   iaddr/ivalid/iready/idata - instruction fetch bus
//   ra_raddr/rb_raddr       - regfile read addresses (1-cycle sync read)
//   ra_rdata/rb_rdata       - regfile read data
//   pc, pc_seq              - current pc from execute (pc_seq debug only)
//   instr_complete          - execute finished the presented instruction
//   decode_valid, instr_c, op_type, op, op_a, op_b, op_c, rd - decode out
//   illegal                 - sticky illegal-instruction flag
module fwrisc_fetch_decode
  import fwrisc_pkg::*;
#(
  parameter int ENABLE_MUL_DIV = 1
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] iaddr,
  output logic        ivalid,
  input  logic        iready,
  input  logic [31:0] idata,
  output logic [5:0]  ra_raddr,
  output logic [5:0]  rb_raddr,
  input  logic [31:0] ra_rdata,
  input  logic [31:0] rb_rdata,
  input  logic [31:0] pc,
  input  logic        pc_seq,
  input  logic        instr_complete,
  output logic        decode_valid,
  output logic        instr_c,
  output logic [4:0]  op_type,
  output logic [5:0]  op,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  output logic [31:0] op_c,
  output logic [5:0]  rd,
  output logic        illegal
);

  localparam logic MUL_DIV_EN = (ENABLE_MUL_DIV != 0);

  fd_state_e   state_q;
  logic        ivalid_q;
  logic        dvalid_q;
  logic        illegal_q;
  logic [5:0]  ra_raddr_q;
  logic [5:0]  rb_raddr_q;
  logic [31:0] instr_q;

  logic        legal_s;
  logic [31:0] imm_i_s, imm_s_s, imm_b_s, imm_u_s, imm_j_s;
  logic [6:0]  opcode_s;
  logic [2:0]  funct3_s;
  logic [6:0]  funct7_s;
  logic [31:0] shamt_s;
  logic        unused_s;

  assign opcode_s = instr_q[6:0];
  assign funct3_s = instr_q[14:12];
  assign funct7_s = instr_q[31:25];
  assign shamt_s  = {27'd0, instr_q[24:20]};
  assign legal_s  = rv32im_legal(instr_q, MUL_DIV_EN);
  assign unused_s = pc_seq;

  fwrisc_imm_gen u_imm_gen (
    .instr_i     (instr_q),
    .imm_itype_o (imm_i_s),
    .imm_stype_o (imm_s_s),
    .imm_btype_o (imm_b_s),
    .imm_utype_o (imm_u_s),
    .imm_jtype_o (imm_j_s)
  );

  // Fetch/decode/execute-handshake state machine with registered requests
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= FD_FETCH;
      ivalid_q   <= 1'b0;
      dvalid_q   <= 1'b0;
      illegal_q  <= 1'b0;
      ra_raddr_q <= 6'd0;
      rb_raddr_q <= 6'd0;
      instr_q    <= 32'd0;
    end else begin
      case (state_q)
        FD_FETCH: begin
          // Only a request we actually raised can be acknowledged
          if (ivalid_q && iready) begin
            instr_q    <= idata;
            ra_raddr_q <= {1'b0, idata[19:15]};
            rb_raddr_q <= {1'b0, idata[24:20]};
            ivalid_q   <= 1'b0;
            state_q    <= FD_DECODE;
          end else begin
            ivalid_q   <= 1'b1;
          end
        end
        FD_DECODE: begin
          if (legal_s) begin
            dvalid_q  <= 1'b1;
            state_q   <= FD_EXEC;
          end else begin
            illegal_q <= 1'b1;
            state_q   <= FD_HALT;
          end
        end
        FD_EXEC: begin
          if (instr_complete) begin
            dvalid_q <= 1'b0;
            ivalid_q <= 1'b1;
            state_q  <= FD_FETCH;
          end else begin
            dvalid_q <= 1'b1;
          end
        end
        FD_HALT: begin
          ivalid_q <= 1'b0;
          dvalid_q <= 1'b0;
        end
        default: begin
          ivalid_q  <= 1'b0;
          dvalid_q  <= 1'b0;
          illegal_q <= 1'b1;
          state_q   <= FD_HALT;
        end
      endcase
    end
  end

  // Combinational field decode from the captured word, regfile data and pc
  always_comb begin
    op_type = OP_TYPE_ARITH;
    op      = OP_ADD;
    op_a    = 32'd0;
    op_b    = 32'd0;
    op_c    = 32'd0;
    rd      = {1'b0, instr_q[11:7]};
    case (opcode_s)
      OPC_OP, OPC_OP_IMM: begin
        op_a = ra_rdata;
        if (opcode_s == OPC_OP) begin
          op_b = rb_rdata;
        end else begin
          op_b = imm_i_s;
        end
        if ((opcode_s == OPC_OP) && (funct7_s == 7'b0000001)) begin
          op_type = OP_TYPE_MDS;
          op      = OP_MUL + {3'b000, funct3_s};
        end else begin
          case (funct3_s)
            3'b000: begin
              // funct7[5] selects SUB only for register-register form
              if ((opcode_s == OPC_OP) && funct7_s[5]) begin
                op = OP_SUB;
              end else begin
                op = OP_ADD;
              end
            end
            3'b001: begin
              op_type = OP_TYPE_MDS;
              op      = OP_SLL;
              if (opcode_s == OPC_OP_IMM) begin
                op_b = shamt_s;
              end else begin
                op_b = rb_rdata;
              end
            end
            3'b101: begin
              op_type = OP_TYPE_MDS;
              if (funct7_s[5]) begin
                op = OP_SRA;
              end else begin
                op = OP_SRL;
              end
              if (opcode_s == OPC_OP_IMM) begin
                op_b = shamt_s;
              end else begin
                op_b = rb_rdata;
              end
            end
            3'b010:  op = OP_SLT;
            3'b011:  op = OP_SLTU;
            3'b100:  op = OP_XOR;
            3'b110:  op = OP_OR;
            3'b111:  op = OP_AND;
            default: op = OP_ADD;
          endcase
        end
      end
      OPC_LUI: begin
        op_a = imm_u_s;
      end
      OPC_AUIPC: begin
        op_a = pc;
        op_b = imm_u_s;
      end
      OPC_BRANCH: begin
        op_type = OP_TYPE_BRANCH;
        op_a    = ra_rdata;
        op_b    = rb_rdata;
        op_c    = imm_b_s;
        rd      = 6'd0;
        case (funct3_s)
          3'b000:  op = OP_EQ;
          3'b001:  op = OP_NE;
          3'b100:  op = OP_LT;
          3'b101:  op = OP_GE;
          3'b110:  op = OP_LTU;
          3'b111:  op = OP_GEU;
          default: op = OP_EQ;
        endcase
      end
      OPC_JAL: begin
        op_type = OP_TYPE_JUMP;
        op_a    = pc;
        op_c    = imm_j_s;
      end
      OPC_JALR: begin
        op_type = OP_TYPE_JUMP;
        op_a    = ra_rdata;
        op_c    = imm_i_s;
      end
      OPC_LOAD: begin
        op_type = OP_TYPE_LDST;
        op_a    = ra_rdata;
        op_b    = rb_rdata;
        op_c    = imm_i_s;
        case (funct3_s)
          3'b000:  op = OP_LB;
          3'b001:  op = OP_LH;
          3'b010:  op = OP_LW;
          3'b100:  op = OP_LBU;
          3'b101:  op = OP_LHU;
          default: op = OP_LW;
        endcase
      end
      OPC_STORE: begin
        op_type = OP_TYPE_LDST;
        op_a    = ra_rdata;
        op_b    = rb_rdata;
        op_c    = imm_s_s;
        rd      = 6'd0;
        case (funct3_s)
          3'b000:  op = OP_SB;
          3'b001:  op = OP_SH;
          default: op = OP_SW;
        endcase
      end
      OPC_MISC_MEM: begin
        rd = 6'd0;
      end
      OPC_SYSTEM: begin
        op_type = OP_TYPE_CSR;
        op      = {3'b000, funct3_s};
        op_c    = {20'd0, instr_q[31:20]};
        // funct3[2] selects the 5-bit zero-extended immediate form
        if (funct3_s[2]) begin
          op_a = {27'd0, instr_q[19:15]};
        end else begin
          op_a = ra_rdata;
        end
      end
      default: begin
        op_type = OP_TYPE_ARITH;
      end
    endcase
  end

  assign iaddr        = pc;
  assign ivalid       = ivalid_q;
  assign ra_raddr     = ra_raddr_q;
  assign rb_raddr     = rb_raddr_q;
  // Cleared combinationally so execute never sees the same instruction twice
  assign decode_valid = dvalid_q & ~instr_complete;
  assign instr_c      = 1'b0;
  assign illegal      = illegal_q;

endmodule

// File: tb/tb_fwrisc_fetch_decode.sv
// Self-checking bench for fwrisc_fetch_decode: a vector table run through a
// scoreboard, plus hand-written handshake, reset and illegal sequences.
module tb_fwrisc_fetch_decode;
  import fwrisc_pkg::*;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  op_type;
    logic [5:0]  op;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] op_c;
    logic        chk_c;
    logic [5:0]  rd;
    logic [5:0]  ra;
    logic [5:0]  rb;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        iready = 1'b0;
  logic [31:0] idata = 32'd0;
  logic [31:0] pc = 32'h8000_0000;
  logic        pc_seq = 1'b1;
  logic        instr_complete = 1'b0;
  logic [31:0] ra_rdata, rb_rdata;

  logic [31:0] iaddr, iaddr1;
  logic        ivalid, ivalid1;
  logic [5:0]  ra_raddr, rb_raddr, ra_raddr1, rb_raddr1;
  logic        decode_valid, decode_valid1;
  logic        instr_c, instr_c1;
  logic [4:0]  op_type, op_type1;
  logic [5:0]  op, op1;
  logic [31:0] op_a, op_b, op_c, op_a1, op_b1, op_c1;
  logic [5:0]  rd, rd1;
  logic        illegal, illegal1;

  int   checks = 0;
  int   failures = 0;
  vec_t sb[$];
  vec_t vtab[11];

  always #5 clock = ~clock;

  fwrisc_fetch_decode #(.ENABLE_MUL_DIV(1)) dut (
    .clock(clock), .reset(reset), .iaddr(iaddr), .ivalid(ivalid), .iready(iready),
    .idata(idata), .ra_raddr(ra_raddr), .rb_raddr(rb_raddr), .ra_rdata(ra_rdata),
    .rb_rdata(rb_rdata), .pc(pc), .pc_seq(pc_seq), .instr_complete(instr_complete),
    .decode_valid(decode_valid), .instr_c(instr_c), .op_type(op_type), .op(op),
    .op_a(op_a), .op_b(op_b), .op_c(op_c), .rd(rd), .illegal(illegal)
  );

  fwrisc_fetch_decode #(.ENABLE_MUL_DIV(0)) dut_nomd (
    .clock(clock), .reset(reset), .iaddr(iaddr1), .ivalid(ivalid1), .iready(iready),
    .idata(idata), .ra_raddr(ra_raddr1), .rb_raddr(rb_raddr1), .ra_rdata(ra_rdata),
    .rb_rdata(rb_rdata), .pc(pc), .pc_seq(pc_seq), .instr_complete(instr_complete),
    .decode_valid(decode_valid1), .instr_c(instr_c1), .op_type(op_type1), .op(op1),
    .op_a(op_a1), .op_b(op_b1), .op_c(op_c1), .rd(rd1), .illegal(illegal1)
  );

  // Register file model: x0 reads 0, others a recognisable pattern
  function automatic logic [31:0] rv(input logic [5:0] a);
    if (a == 6'd0) return 32'd0;
    return 32'hA500_0000 | {26'd0, a};
  endfunction

  // Synchronous one-cycle regfile read driven by the main DUT's addresses
  always_ff @(posedge clock) begin
    ra_rdata <= rv(ra_raddr);
    rb_rdata <= rv(rb_raddr);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  function automatic vec_t mk(input logic [31:0] p, input logic [31:0] w, input logic [4:0] t,
                              input logic [5:0] o, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] c, input logic cc, input logic [5:0] r,
                              input logic [5:0] ra, input logic [5:0] rb);
    vec_t v;
    v.pc = p; v.instr = w; v.op_type = t; v.op = o; v.op_a = a; v.op_b = b;
    v.op_c = c; v.chk_c = cc; v.rd = r; v.ra = ra; v.rb = rb;
    return v;
  endfunction

  // Fetch one instruction (optionally delaying iready), check decode, complete it
  task automatic run_vec(input vec_t v, input int delay);
    int   n;
    vec_t e;
    pc = v.pc;
    #1;
    n = 0;
    while (ivalid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("fetch_ivalid", {31'd0, ivalid}, 32'd1);
    chk("fetch_iaddr", iaddr, v.pc);
    for (int k = 0; k < delay; k++) begin
      tick();
      chk("hold_ivalid", {31'd0, ivalid}, 32'd1);
      chk("hold_iaddr", iaddr, v.pc);
    end
    idata  = v.instr;
    iready = 1'b1;
    sb.push_back(v);
    tick();
    iready = 1'b0;
    idata  = 32'd0;
    chk("decode_cycle_dv", {31'd0, decode_valid}, 32'd0);
    chk("decode_cycle_ivalid", {31'd0, ivalid}, 32'd0);
    chk("ra_raddr", {26'd0, ra_raddr}, {26'd0, v.ra});
    chk("rb_raddr", {26'd0, rb_raddr}, {26'd0, v.rb});
    n = 1;
    while (decode_valid !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    chk("decode_latency", n, 32'd2);
    if (decode_valid === 1'b1 && sb.size() > 0) begin
      e = sb.pop_front();
      chk("op_type", {27'd0, op_type}, {27'd0, e.op_type});
      chk("op", {26'd0, op}, {26'd0, e.op});
      chk("op_a", op_a, e.op_a);
      chk("op_b", op_b, e.op_b);
      if (e.chk_c) chk("op_c", op_c, e.op_c);
      chk("rd", {26'd0, rd}, {26'd0, e.rd});
      chk("instr_c", {31'd0, instr_c}, 32'd0);
      tick();
      chk("dv_hold", {31'd0, decode_valid}, 32'd1);
      chk("raddr_hold", {26'd0, ra_raddr}, {26'd0, v.ra});
    end else begin
      sb.delete();
    end
    instr_complete = 1'b1;
    #1;
    chk("dv_drop_on_complete", {31'd0, decode_valid}, 32'd0);
    tick();
    instr_complete = 1'b0;
    chk("refetch_ivalid", {31'd0, ivalid}, 32'd1);
  endtask

  initial begin
    bit bad_dv, bad_iv, bad_il;
    vtab[0]  = mk(32'h8000_0000, 32'h0050_0093, OP_TYPE_ARITH, OP_ADD, 32'd0, 32'd5, 32'd0, 1'b0, 6'd1, 6'd0, 6'd5);
    vtab[1]  = mk(32'h8000_0004, 32'hFE20_8CE3, OP_TYPE_BRANCH, OP_EQ, rv(6'd1), rv(6'd2), 32'hFFFF_FFF8, 1'b1, 6'd0, 6'd1, 6'd2);
    vtab[2]  = mk(32'h8000_0010, 32'h0100_00EF, OP_TYPE_JUMP, OP_ADD, 32'h8000_0010, 32'd0, 32'd16, 1'b1, 6'd1, 6'd0, 6'd16);
    vtab[3]  = mk(32'h8000_0014, 32'h1234_52B7, OP_TYPE_ARITH, OP_ADD, 32'h1234_5000, 32'd0, 32'd0, 1'b0, 6'd5, 6'd8, 6'd3);
    vtab[4]  = mk(32'h8000_0018, 32'h4020_81B3, OP_TYPE_ARITH, OP_SUB, rv(6'd1), rv(6'd2), 32'd0, 1'b0, 6'd3, 6'd1, 6'd2);
    vtab[5]  = mk(32'h8000_001C, 32'h4030_D213, OP_TYPE_MDS, OP_SRA, rv(6'd1), 32'd3, 32'd0, 1'b0, 6'd4, 6'd1, 6'd3);
    vtab[6]  = mk(32'h8000_0020, 32'h0000_1417, OP_TYPE_ARITH, OP_ADD, 32'h8000_0020, 32'h0000_1000, 32'd0, 1'b0, 6'd8, 6'd0, 6'd0);
    vtab[7]  = mk(32'h8000_0024, 32'hFFC1_2303, OP_TYPE_LDST, OP_LW, rv(6'd2), rv(6'd28), 32'hFFFF_FFFC, 1'b1, 6'd6, 6'd2, 6'd28);
    vtab[8]  = mk(32'h8000_0028, 32'h0070_A423, OP_TYPE_LDST, OP_SW, rv(6'd1), rv(6'd7), 32'd8, 1'b1, 6'd0, 6'd1, 6'd7);
    vtab[9]  = mk(32'h8000_002C, 32'h3000_A4F3, OP_TYPE_CSR, OP_CSRRS, rv(6'd1), 32'd0, 32'h0000_0300, 1'b1, 6'd9, 6'd1, 6'd0);
    vtab[10] = mk(32'h8000_0030, 32'h0220_8033, OP_TYPE_MDS, OP_MUL, rv(6'd1), rv(6'd2), 32'd0, 1'b0, 6'd0, 6'd1, 6'd2);

    // Reset state
    tick(); tick();
    chk("rst_ivalid", {31'd0, ivalid}, 32'd0);
    chk("rst_dv", {31'd0, decode_valid}, 32'd0);
    chk("rst_illegal", {31'd0, illegal}, 32'd0);
    chk("rst_raddr", {20'd0, ra_raddr, rb_raddr}, 32'd0);
    reset = 1'b1;
    tick();
    chk("first_ivalid", {31'd0, ivalid}, 32'd1);

    // Table-driven decode through the scoreboard
    for (int i = 0; i < 11; i++) run_vec(vtab[i], 0);
    chk("nomd_mul_illegal", {31'd0, illegal1}, 32'd1);
    chk("nomd_ivalid_halt", {31'd0, ivalid1}, 32'd0);
    chk("md_mul_legal", {31'd0, illegal}, 32'd0);

    // iready delayed three cycles: request must be held
    vtab[0].pc = 32'h8000_0040;
    run_vec(vtab[0], 3);

    // Reset pulsed while a fetch is outstanding
    pc = 32'h8000_0050;
    #2;
    chk("pre_rst_ivalid", {31'd0, ivalid}, 32'd1);
    reset = 1'b0;
    #1;
    chk("async_rst_ivalid", {31'd0, ivalid}, 32'd0);
    chk("async_rst_nomd_illegal", {31'd0, illegal1}, 32'd0);
    iready = 1'b1;
    idata  = 32'h0000_0000;
    tick();
    chk("rst_late_iready_ivalid", {31'd0, ivalid}, 32'd0);
    iready = 1'b0;
    reset  = 1'b1;
    tick();
    chk("post_rst_ivalid", {31'd0, ivalid}, 32'd1);
    chk("post_rst_iaddr", iaddr, 32'h8000_0050);
    chk("post_rst_illegal", {31'd0, illegal}, 32'd0);
    vtab[0].pc = 32'h8000_0050;
    run_vec(vtab[0], 0);

    // All-zero word is illegal: sticky flag, no decode_valid, fetch stops
    pc = 32'h8000_0060;
    #1;
    chk("ill_fetch_ivalid", {31'd0, ivalid}, 32'd1);
    idata  = 32'h0000_0000;
    iready = 1'b1;
    tick();
    iready = 1'b0;
    tick();
    chk("ill_flag", {31'd0, illegal}, 32'd1);
    chk("ill_flag_nomd", {31'd0, illegal1}, 32'd1);
    bad_dv = 1'b0; bad_iv = 1'b0; bad_il = 1'b0;
    iready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (decode_valid !== 1'b0) bad_dv = 1'b1;
      if (ivalid !== 1'b0) bad_iv = 1'b1;
      if (illegal !== 1'b1) bad_il = 1'b1;
    end
    iready = 1'b0;
    chk("ill_no_dv", {31'd0, bad_dv}, 32'd0);
    chk("ill_no_ivalid", {31'd0, bad_iv}, 32'd0);
    chk("ill_sticky", {31'd0, bad_il}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
